// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light front end and controller:
// lane count, congestion state encoding and default timing constants.
package tl_pkg;

    localparam int NUM_LANES = 2;

    typedef enum logic {
        FREE      = 1'b0,
        CONGESTED = 1'b1
    } cong_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES  = 4;
    localparam int DEF_OCC_CYCLES  = 16;
    localparam int DEF_CLR_CYCLES  = 8;
    localparam int DEF_CNT_W       = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lane_sensor_conditioner_if.sv
// Bundle of detector inputs, controller strobes and conditioned lane outputs
// exchanged between the sensor conditioner and its environment.
interface lane_sensor_conditioner_if
    import tl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic [NUM_LANES-1:0]         det_start;
    logic [NUM_LANES-1:0]         det_queue;
    logic [NUM_LANES-1:0]         demand_clr;
    logic                         count_clr;
    logic [NUM_LANES-1:0]         S1;
    logic [NUM_LANES-1:0]         S5;
    logic [NUM_LANES*CNT_W-1:0]   veh_count;

    modport master (
        output det_start,
        output det_queue,
        output demand_clr,
        output count_clr,
        input  S1,
        input  S5,
        input  veh_count
    );

    modport slave (
        input  det_start,
        input  det_queue,
        input  demand_clr,
        input  count_clr,
        output S1,
        output S5,
        output veh_count
    );

endinterface

// File: rtl/sensor_debounce.sv
// One raw asynchronous detector bit: multi-flop synchronizer followed by a
// debounce counter that only commits a level after DEB_CYCLES stable samples.
module sensor_debounce
    import tl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = level_q;

    // The counter only survives while the synced level disagrees with the
    // committed one, so any agreeing sample throws away partial progress.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d   = '0;
        level_d = level_q;
        if (synced != level_q) begin
            if (cnt_q == DEB_LAST) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/lane_sensor_conditioner.sv
// Front end of the traffic-light controller: cleans per-lane loop detectors into
// a latched demand (S1), a hysteretic congestion flag (S5) and vehicle counts.
module lane_sensor_conditioner
    import tl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int OCC_CYCLES  = DEF_OCC_CYCLES,
    parameter int CLR_CYCLES  = DEF_CLR_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    lane_sensor_conditioner_if.slave  bus
);

    localparam int OCW = $clog2(max_int(OCC_CYCLES, CLR_CYCLES) + 1);
    localparam logic [OCW-1:0]   OCC_LAST = OCW'(OCC_CYCLES - 1);
    localparam logic [OCW-1:0]   CLR_LAST = OCW'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_LANES-1:0] start_lvl;
    logic [NUM_LANES-1:0] queue_lvl;
    logic [NUM_LANES-1:0] start_prev_q;
    logic [NUM_LANES-1:0] start_prev_d;
    logic [NUM_LANES-1:0] rise;
    logic [NUM_LANES-1:0] s1_q;
    logic [NUM_LANES-1:0] s1_d;
    logic [CNT_W-1:0]     cnt_q   [NUM_LANES];
    logic [CNT_W-1:0]     cnt_d   [NUM_LANES];
    cong_state_e          state_q [NUM_LANES];
    cong_state_e          state_d [NUM_LANES];
    logic [OCW-1:0]       occ_q   [NUM_LANES];
    logic [OCW-1:0]       occ_d   [NUM_LANES];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sensor_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_start_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.det_start[g]),
            .level (start_lvl[g])
        );

        sensor_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_queue_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.det_queue[g]),
            .level (queue_lvl[g])
        );
    end

    // A new arrival beats a same-cycle service strobe, and a same-cycle
    // counter clear still records that arrival.
    always_comb begin
        start_prev_d = start_lvl;
        rise         = start_lvl & ~start_prev_q;
        s1_d         = s1_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            cnt_d[l] = cnt_q[l];
            if (rise[l]) begin
                s1_d[l] = 1'b1;
            end else if (bus.demand_clr[l]) begin
                s1_d[l] = 1'b0;
            end
            if (bus.count_clr) begin
                cnt_d[l] = rise[l] ? CNT_W'(1) : '0;
            end else if (rise[l] && (cnt_q[l] != CNT_MAX)) begin
                cnt_d[l] = cnt_q[l] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            state_d[l] = state_q[l];
            occ_d[l]   = '0;
            case (state_q[l])
                FREE: begin
                    if (queue_lvl[l]) begin
                        if (occ_q[l] == OCC_LAST) begin
                            state_d[l] = CONGESTED;
                        end else begin
                            occ_d[l] = occ_q[l] + OCW'(1);
                        end
                    end
                end
                CONGESTED: begin
                    if (!queue_lvl[l]) begin
                        if (occ_q[l] == CLR_LAST) begin
                            state_d[l] = FREE;
                        end else begin
                            occ_d[l] = occ_q[l] + OCW'(1);
                        end
                    end
                end
                default: state_d[l] = FREE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_prev_q <= '0;
            s1_q         <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                cnt_q[l]   <= '0;
                state_q[l] <= FREE;
                occ_q[l]   <= '0;
            end
        end else begin
            start_prev_q <= start_prev_d;
            s1_q         <= s1_d;
            for (int l = 0; l < NUM_LANES; l++) begin
                cnt_q[l]   <= cnt_d[l];
                state_q[l] <= state_d[l];
                occ_q[l]   <= occ_d[l];
            end
        end
    end

    always_comb begin
        bus.S1        = s1_q;
        bus.S5        = '0;
        bus.veh_count = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            bus.S5[l]                      = (state_q[l] == CONGESTED);
            bus.veh_count[l*CNT_W +: CNT_W] = cnt_q[l];
        end
    end

endmodule
